muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/rv32i_pkg.sv | 37 +++
 rtl/muldiv_iter.sv | 55 +++++
 rtl/muldiv_seq.sv | 126 ++++++++++++
 tb/tb_muldiv_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: ALU ops, opcode one-hots, M-extension op and sequencer state encodings.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  // One-hot opcode classes as produced by decode
  localparam logic [8:0] OPC_LUI    = 9'b0_0000_0001;
  localparam logic [8:0] OPC_AUIPC  = 9'b0_0000_0010;
  localparam logic [8:0] OPC_JAL    = 9'b0_0000_0100;
  localparam logic [8:0] OPC_JALR   = 9'b0_0000_1000;
  localparam logic [8:0] OPC_BRANCH = 9'b0_0001_0000;
  localparam logic [8:0] OPC_LOAD   = 9'b0_0010_0000;
  localparam logic [8:0] OPC_STORE  = 9'b0_0100_0000;
  localparam logic [8:0] OPC_OPIMM  = 9'b0_1000_0000;
  localparam logic [8:0] OPC_OP     = 9'b1_0000_0000;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: one radix-2 shift-add (multiply) or restoring-divide step per run cycle.
// acc holds {hi, lo}: product, or {remainder, quotient}; last flags iteration 31.
module muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        run,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc,
  output logic        last
);

  logic [31:0] b_q;
  logic        div_q;
  logic [5:0]  cnt;
  logic [32:0] mul_sum;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        fits;
  logic [63:0] step;

  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
    // Remainder stays below the divisor, so 32 bits hold it after each step
    shifted = {acc[63:32], acc[31]};
    trial   = shifted - {1'b0, b_q};
    fits    = ~trial[32];
    if (div_q)
      step = {(fits ? trial[31:0] : shifted[31:0]), acc[30:0], fits};
    else
      step = {mul_sum, acc[31:1]};
  end

  assign last = (cnt == 6'd31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= 64'd0;
      b_q   <= 32'd0;
      div_q <= 1'b0;
      cnt   <= 6'd0;
    end else if (load) begin
      acc   <= {32'd0, a};
      b_q   <= b;
      div_q <= is_div;
      cnt   <= 6'd0;
    end else if (run) begin
      acc <= step;
      if (!last) cnt <= cnt + 6'd1;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M sequential multiply/divide: FSM, operand conditioning, special cases and sign fix-up.
// Normal ops complete 33 cycles after accept; divide-by-zero and signed overflow complete in 1.
module muldiv_seq
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        force_stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   state, state_nxt;
  logic        accept;
  logic        a_sgn, b_sgn, a_neg, b_neg, is_div, div0, ovf;
  logic [31:0] a_mag, b_mag;
  logic [2:0]  f3_q;
  logic [31:0] a_q;
  logic        a_neg_q, b_neg_q, div0_q, ovf_q;
  logic [31:0] res_q;
  logic [63:0] acc;
  logic        last;
  logic [63:0] prod;
  logic [31:0] quo, rem, fixed;

  assign accept = (state == MD_IDLE) && start && !flush;

  always_comb begin
    is_div = funct3[2];
    a_sgn  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_sgn  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg  = a_sgn & rs1_data[31];
    b_neg  = b_sgn & rs2_data[31];
    a_mag  = a_neg ? -rs1_data : rs1_data;
    b_mag  = b_neg ? -rs2_data : rs2_data;
    div0   = is_div && (rs2_data == 32'd0);
    ovf    = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
             (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  end

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .run    (state == MD_CALC),
    .is_div (is_div),
    .a      (a_mag),
    .b      (b_mag),
    .acc    (acc),
    .last   (last)
  );

  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
    quo  = (a_neg_q ^ b_neg_q) ? -acc[31:0] : acc[31:0];
    rem  = a_neg_q ? -acc[63:32] : acc[63:32];
    unique case (muldiv_op_e'(f3_q))
      F3_MUL:                        fixed = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fixed = prod[63:32];
      F3_DIV, F3_DIVU:               fixed = div0_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo);
      default:                       fixed = div0_q ? a_q : (ovf_q ? 32'd0 : rem);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    force_stall = 1'b0;
    result      = res_q;
    unique case (state)
      MD_IDLE: begin
        force_stall = accept & ~rst;
        if (accept) state_nxt = (div0 || ovf) ? MD_DONE : MD_CALC;
      end
      MD_CALC: begin
        busy        = 1'b1;
        force_stall = ~rst;
        if (flush)     state_nxt = MD_IDLE;
        else if (last) state_nxt = MD_DONE;
      end
      MD_DONE: begin
        busy      = 1'b1;
        done      = ~flush;
        result    = flush ? res_q : fixed;
        state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Operand sign/special-case context is captured at accept for the DONE fix-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q    <= 3'd0;
      a_q     <= 32'd0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      if (accept) begin
        f3_q    <= funct3;
        a_q     <= rs1_data;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        div0_q  <= div0;
        ovf_q   <= ovf;
      end
      if (done) res_q <= fixed;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        force_stall, busy, done;
  logic [31:0] result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .funct3      (funct3),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .force_stall (force_stall),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4 && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issues one op, checks stall every cycle, latency, and result. poke_cyc>0 re-asserts
  // start with junk operands mid-op, which must be ignored.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int poke_cyc);
    int lat, cyc;
    logic seen;
    lat = ref_lat(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    #1;
    check({tag, ":stall_c0"}, {31'd0, force_stall}, 32'd1);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      start    = (cyc + 1 == poke_cyc);
      funct3   = 3'($urandom);
      rs1_data = $urandom;
      rs2_data = $urandom;
      #1;
      cyc++;
      if (done) seen = 1'b1;
      else check({tag, ":stall"}, {31'd0, force_stall}, {31'd0, cyc < lat});
    end
    start = 1'b0;
    check({tag, ":latency"}, seen ? cyc : 32'd999, lat);
    if (seen) begin
      last_res = ref_res(f, a, b);
      check({tag, ":stall_done"}, {31'd0, force_stall}, 32'd0);
      check({tag, ":busy_done"}, {31'd0, busy}, 32'd1);
      check({tag, ":result"}, result, last_res);
    end
  endtask

  initial begin
    int pulses;
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    last_res = 32'd0;
    #1;
    check("rst:busy", {31'd0, busy}, 32'd0);
    check("rst:done", {31'd0, done}, 32'd0);
    check("rst:stall", {31'd0, force_stall}, 32'd0);
    check("rst:result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("mul_7_m3",   3'd0, 32'd7,          32'hFFFF_FFFD, 0);
    do_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    do_op("mulh_ff",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    do_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF,  32'd2,         0);
    do_op("div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,         0);
    do_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,         0);
    do_op("divu_100_7", 3'd5, 32'd100,        32'd7,         0);
    do_op("remu_100_7", 3'd7, 32'd100,        32'd7,         0);
    do_op("div_by0",    3'd4, 32'd100,        32'd0,         0);
    do_op("rem_by0",    3'd6, 32'd100,        32'd0,         0);
    do_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    do_op("mul_poke",   3'd0, 32'd3,          32'd5,         3);

    // Flush at cycle 10 of a DIV, then a fresh MUL
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush:done_c10", {31'd0, done}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush:busy", {31'd0, busy}, 32'd0);
    check("flush:stall", {31'd0, force_stall}, 32'd0);
    check("flush:done", {31'd0, done}, 32'd0);
    check("flush:result", result, last_res);
    do_op("mul_after_flush", 3'd0, 32'd3, 32'd5, 0);

    // start together with flush in IDLE is not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9;
    #1;
    check("stflush:stall", {31'd0, force_stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("stflush:busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    repeat (36) begin
      tick();
      if (done) pulses++;
    end
    check("stflush:no_done", pulses, 32'd0);
    check("stflush:result", result, last_res);

    // Reset pulsed at cycle 5 of a MUL
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    #1;
    check("midrst:busy", {31'd0, busy}, 32'd0);
    check("midrst:done", {31'd0, done}, 32'd0);
    check("midrst:stall", {31'd0, force_stall}, 32'd0);
    check("midrst:result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    last_res = 32'd0;
    pulses = 0;
    repeat (40) begin
      tick();
      if (done) pulses++;
    end
    check("midrst:no_done", pulses, 32'd0);
    check("midrst:result_after", result, 32'd0);

    // Randomized ops, with operand corner values mixed in
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, (i % 5 == 0) ? 7 : 0);
    end
    tick();
    check("final:done_low", {31'd0, done}, 32'd0);
    check("final:result_held", result, last_res);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
